// File: rtl/feistel_pkg.sv
// Shared types and key-index helpers for the parametrised Feistel core.
//   state_t        : block-processing state (IDLE, ROUND, FINAL, OUT)
//   white_idx_t    : pair of whitening-key indices {wl, wr}
//   round_key_idx  : round-key index for round r in the chosen direction
//   white_idx      : whitening-key indices for the chosen direction
package feistel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    OUT
  } state_t;

  typedef struct packed {
    int unsigned wl;
    int unsigned wr;
  } white_idx_t;

  // Decryption walks the key schedule backwards, starting from K[ROUNDS+1].
  function automatic int unsigned round_key_idx(input int unsigned r,
                                                input logic        encrypt,
                                                input int unsigned rounds);
    return encrypt ? r : (rounds + 1 - r);
  endfunction

  function automatic white_idx_t white_idx(input logic        encrypt,
                                           input int unsigned rounds);
    white_idx_t w;
    if (encrypt) begin
      w.wl = rounds + 1;
      w.wr = rounds;
    end else begin
      w.wl = 0;
      w.wr = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/feistel_key_sel.sv
// Combinational subkey selection for the Feistel core.
//   subkeys   : flattened key bus, K[i] = subkeys[i*HALF_W +: HALF_W]
//   rnd       : current round index
//   encrypt   : 1 = encrypt schedule, 0 = decrypt schedule
//   round_key : key mixed into the F argument this round
//   wl_key    : whitening key for the output left half
//   wr_key    : whitening key for the output right half
module feistel_key_sel
  import feistel_pkg::*;
#(
  parameter int HALF_W = 64,
  parameter int ROUNDS = 8,
  parameter int R_W    = 3
) (
  input  logic [(ROUNDS+2)*HALF_W-1:0] subkeys,
  input  logic [R_W-1:0]               rnd,
  input  logic                         encrypt,
  output logic [HALF_W-1:0]            round_key,
  output logic [HALF_W-1:0]            wl_key,
  output logic [HALF_W-1:0]            wr_key
);

  localparam int NK   = ROUNDS + 2;
  localparam int KI_W = $clog2(NK);

  logic [HALF_W-1:0] k_arr [NK];
  white_idx_t        w;
  logic [KI_W-1:0]   rk_idx;
  logic [KI_W-1:0]   wl_idx;
  logic [KI_W-1:0]   wr_idx;

  for (genvar i = 0; i < NK; i++) begin : g_unpack
    assign k_arr[i] = subkeys[i*HALF_W +: HALF_W];
  end

  always_comb begin
    w         = white_idx(encrypt, ROUNDS);
    rk_idx    = KI_W'(round_key_idx(32'(rnd), encrypt, ROUNDS));
    wl_idx    = KI_W'(w.wl);
    wr_idx    = KI_W'(w.wr);
    round_key = k_arr[rk_idx];
    wl_key    = k_arr[wl_idx];
    wr_key    = k_arr[wr_idx];
  end

endmodule

// File: rtl/feistel_core_param.sv
// Parametrised iterative Feistel core, one block in flight at a time.
// Blocks enter on in_valid/in_ready, each round calls an external F unit
// over f_req/f_x/f_ack/f_y, a final whitening step forms the result, which
// leaves on out_valid/out_ready. Losing key_valid mid-block drops the block
// and pulses abort.
//   Clk, RstN          : clock, asynchronous active-low reset
//   key_valid, subkeys : subkey bus, K[i] = subkeys[i*HALF_W +: HALF_W]
//   in_*               : input block {L,R} and per-block direction
//   f_*                : F-function request/acknowledge port
//   out_*              : result block handshake
//   abort              : one-cycle pulse when a block is dropped
//   blk_count          : completed-block counter; present only when
//                        FEISTEL_BLOCK_CNT_EN is defined, otherwise 0
module feistel_core_param
  import feistel_pkg::*;
#(
  parameter  int BLOCK_W = 128,
  parameter  int ROUNDS  = 8,
  parameter  int CNT_W   = 32,
  localparam int HALF_W  = BLOCK_W / 2,
  localparam int NK      = ROUNDS + 2
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic                 key_valid,
  input  logic [NK*HALF_W-1:0] subkeys,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BLOCK_W-1:0]   in_block,
  input  logic                 in_encrypt,
  output logic                 f_req,
  output logic [HALF_W-1:0]    f_x,
  input  logic                 f_ack,
  input  logic [HALF_W-1:0]    f_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BLOCK_W-1:0]   out_block,
  output logic                 abort,
  output logic [CNT_W-1:0]     blk_count
);

  localparam int R_W = $clog2(ROUNDS);

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   left_q, left_d;
  logic [HALF_W-1:0]   right_q, right_d;
  logic [R_W-1:0]      rnd_q, rnd_d;
  logic                enc_q, enc_d;
  logic [BLOCK_W-1:0]  out_block_q, out_block_d;
  logic                abort_q, abort_d;

  logic [HALF_W-1:0]   round_key;
  logic [HALF_W-1:0]   wl_key;
  logic [HALF_W-1:0]   wr_key;
  logic [HALF_W-1:0]   f_arg;

  feistel_key_sel #(
    .HALF_W (HALF_W),
    .ROUNDS (ROUNDS),
    .R_W    (R_W)
  ) u_key_sel (
    .subkeys   (subkeys),
    .rnd       (rnd_q),
    .encrypt   (enc_q),
    .round_key (round_key),
    .wl_key    (wl_key),
    .wr_key    (wr_key)
  );

  // f_x only moves when left_q/rnd_q do, i.e. in the cycle after an f_ack.
  assign f_arg     = left_q ^ round_key;
  assign f_x       = (state_q == ROUND) ? f_arg : '0;
  assign f_req     = (state_q == ROUND);
  assign in_ready  = (state_q == IDLE) && key_valid;
  assign out_valid = (state_q == OUT);
  assign out_block = out_block_q;
  assign abort     = abort_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    rnd_d       = rnd_q;
    enc_d       = enc_q;
    out_block_d = out_block_q;
    abort_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && key_valid) begin
          left_d  = in_block[BLOCK_W-1:HALF_W];
          right_d = in_block[HALF_W-1:0];
          enc_d   = in_encrypt;
          rnd_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        // Key loss wins over a simultaneous f_ack: the block is dropped.
        if (!key_valid) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (f_ack) begin
          left_d  = right_q ^ f_y;
          right_d = f_arg;
          rnd_d   = rnd_q + R_W'(1);
          if (rnd_q == R_W'(ROUNDS - 1)) begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        if (!key_valid) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          out_block_d = {right_q ^ wl_key, left_q ^ wr_key};
          state_d     = OUT;
        end
      end
      OUT: begin
        // Key loss here is deliberately ignored: the result is already final.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= IDLE;
      left_q      <= '0;
      right_q     <= '0;
      rnd_q       <= '0;
      enc_q       <= 1'b0;
      out_block_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      rnd_q       <= rnd_d;
      enc_q       <= enc_d;
      out_block_q <= out_block_d;
      abort_q     <= abort_d;
    end
  end

`ifdef FEISTEL_BLOCK_CNT_EN
  logic [CNT_W-1:0] blk_count_q, blk_count_d;

  // Wraps naturally at 2^CNT_W.
  always_comb begin
    blk_count_d = blk_count_q;
    if (out_valid && out_ready) begin
      blk_count_d = blk_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      blk_count_q <= '0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign blk_count = blk_count_q;
`else
  assign blk_count = '0;
`endif

endmodule

// File: doc/feistel_core_param.md
Name: feistel_core_param

Overview:
Parametrised successor to the fixed 128-bit Feistel core. It processes a stream of blocks through a configurable-width, configurable-round Feistel network with per-block encrypt/decrypt selection. Blocks enter and leave on valid/ready handshakes, and the F function is called over an external req/ack port. It sits between the subkey generator (flattened subkey bus plus key_valid) and the shared F-function unit.

Parameters:
BLOCK_W, 128, block width in bits; must be even; HALF_W = BLOCK_W/2
ROUNDS, 8, number of Feistel rounds; must be at least 2; subkey count NK = ROUNDS+2
CNT_W, 32, width of the optional block counter

Ports:
Clk  in  1  clock
RstN  in  1  reset
key_valid  in  1  subkeys stable and usable
subkeys  in  NK*HALF_W  K[i] = subkeys[i*HALF_W +: HALF_W]
in_valid  in  1  input block offered
in_ready  out  1  core can accept a block
in_block  in  BLOCK_W  {L,R}, L = upper half
in_encrypt  in  1  1 = encrypt, 0 = decrypt; sampled with the block
f_req  out  1  F transaction active
f_x  out  HALF_W  F argument
f_ack  in  1  single-cycle pulse; f_y valid in the same cycle
f_y  in  HALF_W  F result
out_valid  out  1  result block valid
out_ready  in  1  downstream accepts the result
out_block  out  BLOCK_W  result {L,R}
abort  out  1  one-cycle pulse: block dropped
blk_count  out  CNT_W  completed-block counter (optional feature)

Behaviour:
- Clocking and reset: one clock, Clk. Reset RstN is asynchronous, active-low.
- Reset values: state IDLE; in_ready=0 until key_valid; f_req=0; f_x=0; out_valid=0; out_block=0; abort=0; blk_count=0; round index r=0.
- States:
  - IDLE: in_ready = key_valid. On in_valid&&in_ready, capture L, R and mode, set r=0, go to ROUND.
  - ROUND: f_req=1 and f_x = L ^ K[k]. k = r for encrypt; k = ROUNDS+1-r for decrypt. On f_ack: L <= R ^ f_y, R <= f_x, r++. If r was ROUNDS-1, go to FINAL.
  - FINAL (1 cycle): out_L = R ^ K[wl], out_R = L ^ K[wr]. Encrypt uses wl=ROUNDS+1, wr=ROUNDS. Decrypt uses wl=0, wr=1. Go to OUT.
  - OUT: out_valid=1; out_block is held stable until out_ready. On transfer go to IDLE.
- F handshake: f_x changes only in the cycle after an f_ack. f_req stays high across rounds; each f_ack ends exactly one transaction. f_ack while f_req=0 is ignored.
- Latency: with an F unit that acks one cycle after a transaction starts, an acceptance in cycle 0 gives out_valid in cycle 2*ROUNDS+2.
- Back-to-back blocks: in_ready rises in the cycle after an OUT transfer. There is no overlap between blocks.
- key_valid falls in ROUND or FINAL: drop the block, f_req=0, pulse abort for 1 cycle, go to IDLE.
- key_valid falls in OUT: the result completes normally.
- Reset mid-operation: everything returns immediately to reset values; no out_valid is produced.
- out_ready already high on entry to OUT: the transfer happens in the first OUT cycle.

Optional Feature:
FEISTEL_BLOCK_CNT_EN
- Defined: blk_count increments on each out_valid&&out_ready. It wraps modulo 2^CNT_W and is cleared only by reset.
- Undefined: blk_count is tied to 0 and no counter flops exist.

Decomposition:
- Package feistel_pkg holds:
  - state typedef (IDLE, ROUND, FINAL, OUT);
  - a function returning the round-key index from (r, encrypt, ROUNDS);
  - a function returning the whitening indices.
- Sub-module feistel_key_sel: combinational selection of the round key and both whitening keys from subkeys, r and mode.

Test Plan:
- All K=0, F returns 0, encrypt in_block=0x0011223344556677_8899AABBCCDDEEFF -> out_block=0x8899AABBCCDDEEFF_0011223344556677; out_valid in cycle 18 with 1-cycle F.
- K[i]=i replicated, F model f_y = rotl(f_x,7) ^ 0x5A5A...: encrypt a random block, then decrypt the result -> original block; 20 random blocks.
- out_ready held low for 10 cycles in OUT -> out_valid and out_block stable, in_ready=0; release -> transfer, in_ready=1 the next cycle.
- key_valid dropped during round 3 -> f_req=0 next cycle, abort pulses once, no out_valid; the next block processes correctly.
- RstN asserted mid-ROUND -> all outputs at reset values asynchronously; after release, a fresh block gives the correct result.
- With FEISTEL_BLOCK_CNT_EN: 5 back-to-back blocks -> blk_count=5. Without the macro: blk_count=0 throughout.
